// File: rtl/matrix_pkg.sv
// Shared sizing and FSM state type for the matrix column streamer.
package matrix_pkg;

  localparam int ROWS_DEF    = 4;
  localparam int COLUMNS_DEF = 8;
  localparam int ROW_IDX_W   = $clog2(ROWS_DEF);
  localparam int COL_IDX_W   = $clog2(COLUMNS_DEF);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

endpackage

// File: rtl/matrix_column_streamer_column_select.sv
// Combinational corner-turn slice: gathers bit sel of every row word into one column.
module column_select
  import matrix_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLUMNS = COLUMNS_DEF,
  parameter int CW      = $clog2(COLUMNS)
) (
  input  logic [ROWS-1:0][COLUMNS-1:0] rows,
  input  logic [CW-1:0]                sel,
  output logic [ROWS-1:0]              slice
);

  always_comb begin
    slice = '0;
    for (int j = 0; j < ROWS; j++) begin
      slice[j] = rows[j][sel];
    end
  end

endmodule

// File: rtl/matrix_column_streamer.sv
// Double-buffered corner-turn buffer: host fills a shadow matrix by rows, the active matrix
// streams out by columns. Define STREAM_REPEAT_EN to re-stream the active matrix indefinitely.
module matrix_column_streamer
  import matrix_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLUMNS = COLUMNS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [COLUMNS-1:0]         wr_data,
  input  logic                       commit,
  input  logic                       col_ready,
  output logic                       col_valid,
  output logic [ROWS-1:0]            col_data,
  output logic [$clog2(COLUMNS)-1:0] col_index,
  output logic                       col_last,
  output logic                       pending
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLUMNS);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLUMNS - 1);
  localparam logic [RW:0]   ROW_LIMIT = (RW + 1)'(ROWS);

  state_t                      state;
  logic [ROWS-1:0][COLUMNS-1:0] shadow;
  logic [ROWS-1:0][COLUMNS-1:0] shadow_next;
  logic [ROWS-1:0][COLUMNS-1:0] active;
  logic                        handshake;
  logic                        at_last;

  // A write in the same cycle as a load is forwarded so the load sees it.
  always_comb begin
    shadow_next = shadow;
    if (wr_en && ({1'b0, wr_row} < ROW_LIMIT)) begin
      shadow_next[wr_row] = wr_data;
    end
  end

  assign handshake = col_valid && col_ready;
  assign at_last   = (col_index == LAST_COL);
  assign col_last  = col_valid && at_last;

  column_select #(
    .ROWS    (ROWS),
    .COLUMNS (COLUMNS),
    .CW      (CW)
  ) u_select (
    .rows  (active),
    .sel   (col_index),
    .slice (col_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      active    <= '0;
      col_valid <= 1'b0;
      col_index <= '0;
      pending   <= 1'b0;
    end else begin
      shadow <= shadow_next;
      case (state)
        ST_IDLE: begin
          if (commit) begin
            active    <= shadow_next;
            col_index <= '0;
            col_valid <= 1'b1;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // Commits during a pass only arm the reload; data is sampled when it happens.
          if (commit) begin
            pending <= 1'b1;
          end
          if (handshake) begin
            if (!at_last) begin
              col_index <= col_index + 1'b1;
            end else if (pending || commit) begin
              active    <= shadow_next;
              col_index <= '0;
              pending   <= 1'b0;
            end else begin
`ifdef STREAM_REPEAT_EN
              col_index <= '0;
`else
              col_index <= '0;
              col_valid <= 1'b0;
              state     <= ST_IDLE;
`endif
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          col_valid <= 1'b0;
          col_index <= '0;
          pending   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_column_streamer.sv
// Directed bench for matrix_column_streamer; a row-matrix model feeds a column scoreboard.
module tb_matrix_column_streamer;
  import matrix_pkg::*;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] index;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [7:0] wr_data;
  logic       commit;
  logic       col_ready;
  logic       col_valid;
  logic [3:0] col_data;
  logic [2:0] col_index;
  logic       col_last;
  logic       pending;

  exp_t       sb[$];
  logic [7:0] model [4];
  int         tests_run    = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  matrix_column_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .commit    (commit),
    .col_ready (col_ready),
    .col_valid (col_valid),
    .col_data  (col_data),
    .col_index (col_index),
    .col_last  (col_last),
    .pending   (pending)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    tests_run++;
    tests_failed++;
    $error("[TB] FAIL %s: timed out waiting, got none expected event", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected columns come from the bench's own row model, one entry per column.
  task automatic pushMatrix();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 4; j++) e.data[j] = model[j][c];
      e.index = 3'(c);
      e.last  = (c == 7);
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] row, input logic [7:0] data,
                               input logic cm);
    wr_en   = we;
    wr_row  = row;
    wr_data = data;
    commit  = cm;
    if (we) model[row] = data;
    tick();
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic writeMatrix(input logic [7:0] r0, input logic [7:0] r1,
                             input logic [7:0] r2, input logic [7:0] r3);
    applyStimulus(1'b1, 2'd0, r0, 1'b0);
    applyStimulus(1'b1, 2'd1, r1, 1'b0);
    applyStimulus(1'b1, 2'd2, r2, 1'b0);
    applyStimulus(1'b1, 2'd3, r3, 1'b0);
  endtask

  task automatic waitIndex(input int idx, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (col_valid && col_index == 3'(idx)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) reportTimeout(tag);
  endtask

  task automatic waitEmpty(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) reportTimeout(tag);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    sb.delete();
    for (int j = 0; j < 4; j++) model[j] = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  // A repeating build never idles, so a pass is closed with a reset instead.
  task automatic finishPass(input string tag);
    waitEmpty(tag);
`ifdef STREAM_REPEAT_EN
    doReset();
`else
    checkOutput({tag, "_idle"}, 32'(col_valid), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && col_valid && col_ready) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("[TB] FAIL extra_column: got index %0d expected no column", col_index);
      end else begin
        e = sb.pop_front();
        checkOutput("col_data",  32'(col_data),  32'(e.data));
        checkOutput("col_index", 32'(col_index), 32'(e.index));
        checkOutput("col_last",  32'(col_last),  32'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t held;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_row    = 2'd0;
    wr_data   = 8'h00;
    commit    = 1'b0;
    col_ready = 1'b0;
    for (int j = 0; j < 4; j++) model[j] = 8'h00;
    tick();
    tick();
    checkOutput("rst_valid",   32'(col_valid), 32'd0);
    checkOutput("rst_index",   32'(col_index), 32'd0);
    checkOutput("rst_last",    32'(col_last),  32'd0);
    checkOutput("rst_pending", 32'(pending),   32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic single pass");
    col_ready = 1'b1;
    writeMatrix(8'hA5, 8'h3C, 8'hFF, 8'h00);
    checkOutput("idle_before_commit", 32'(col_valid), 32'd0);
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("commit_latency", 32'(col_valid), 32'd1);
    checkOutput("basic_pending",  32'(pending),   32'd0);
    finishPass("basic");

    $display("[TB] backpressure at column 3");
    writeMatrix(8'h96, 8'h5A, 8'h0F, 8'hC3);
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitIndex(3, "bp_reach3");
    col_ready = 1'b0;
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid", 32'(col_valid), 32'd1);
      checkOutput("bp_index", 32'(col_index), 32'd3);
      checkOutput("bp_data",  32'(col_data),  32'(held.data));
    end
    col_ready = 1'b1;
    finishPass("bp");

    $display("[TB] double buffer reload");
    writeMatrix(8'h12, 8'h34, 8'h56, 8'h78);
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitIndex(2, "db_reach2");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("db_pending_set", 32'(pending), 32'd1);
    writeMatrix(8'hE1, 8'h2D, 8'hB4, 8'h4B);
    pushMatrix();
    checkOutput("db_at_last",      32'(col_index), 32'd7);
    checkOutput("db_pending_hold", 32'(pending),   32'd1);
    tick();
    checkOutput("db_no_bubble",    32'(col_valid), 32'd1);
    checkOutput("db_new_index",    32'(col_index), 32'd0);
    checkOutput("db_pending_clr",  32'(pending),   32'd0);
    finishPass("db");

    $display("[TB] same-cycle write and commit");
    writeMatrix(8'h11, 8'h22, 8'h44, 8'h88);
    col_ready = 1'b0;
    model[1] = 8'hF0;
    pushMatrix();
    applyStimulus(1'b1, 2'd1, 8'hF0, 1'b1);
    checkOutput("fwd_valid", 32'(col_valid), 32'd1);
    checkOutput("fwd_index", 32'(col_index), 32'd0);
    col_ready = 1'b1;
    finishPass("fwd");

    $display("[TB] reset mid-stream");
    writeMatrix(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitIndex(1, "mr_reach1");
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    checkOutput("mr_pending_pre", 32'(pending), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid",   32'(col_valid), 32'd0);
    checkOutput("mr_index",   32'(col_index), 32'd0);
    checkOutput("mr_pending", 32'(pending),   32'd0);
    checkOutput("mr_data",    32'(col_data),  32'd0);
    sb.delete();
    for (int j = 0; j < 4; j++) model[j] = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] repeat behaviour");
    writeMatrix(8'h81, 8'h42, 8'h24, 8'h18);
`ifdef STREAM_REPEAT_EN
    pushMatrix();
    pushMatrix();
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitEmpty("rep_three_passes");
    checkOutput("rep_still_valid", 32'(col_valid), 32'd1);
    doReset();
`else
    pushMatrix();
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1);
    waitEmpty("rep_single_pass");
    for (int i = 0; i < 3; i++) begin
      checkOutput("rep_stays_idle", 32'(col_valid), 32'd0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
